// File: rtl/rvm_mem_master_pkg.sv
// Shared definitions for the core-side SRAM bus initiator: access size codes,
// FSM state encoding, reset address and the read-data extension helper.
package rvm_mem_master_pkg;

    typedef enum logic [1:0] {
        MEM_SIZE_B = 2'd0,
        MEM_SIZE_H = 2'd1,
        MEM_SIZE_W = 2'd2,
        MEM_SIZE_X = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] mem_extend(input logic [31:0] v,
                                               input mem_size_e   size,
                                               input logic        sgn);
        logic [31:0] r;
        case (size)
            MEM_SIZE_B: r = {{24{sgn & v[7]}}, v[7:0]};
            MEM_SIZE_H: r = {{16{sgn & v[15]}}, v[15:0]};
            default:    r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rvm_mem_master_if.sv
// Stall/error SRAM bus between the memory initiator and the responder.
interface rvm_mem_master_if;

    logic [31:0] mem_addr;
    logic [3:0]  mem_ben;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        mem_error;

    modport master (
        output mem_addr, mem_ben, mem_wen, mem_wdata,
        input  mem_rdata, mem_stall, mem_error
    );

    modport slave (
        input  mem_addr, mem_ben, mem_wen, mem_wdata,
        output mem_rdata, mem_stall, mem_error
    );

endinterface

// File: rtl/rvm_mem_master_align.sv
// Combinational lane logic: byte-enable and write-data steering, alignment
// check, and read-data extract/extend. Shared with the data-side LSU.
module rvm_mem_master_align
    import rvm_mem_master_pkg::*;
(
    input  mem_size_e   size,
    input  logic        sign_ext,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        misaligned,
    output logic [3:0]  ben,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    always_comb begin
        misaligned = 1'b0;
        ben        = 4'h0;
        wdata_lane = 32'h0;
        case (size)
            MEM_SIZE_B: begin
                ben        = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
            end
            MEM_SIZE_H: begin
                misaligned = offset[0];
                ben        = 4'b0011 << offset;
                wdata_lane = {2{wdata[15:0]}};
            end
            MEM_SIZE_W: begin
                misaligned = |offset;
                ben        = 4'hF;
                wdata_lane = wdata;
            end
            default: misaligned = 1'b1;
        endcase
    end

    assign rdata_ext = mem_extend(rdata >> {offset, 3'b000}, size, sign_ext);

endmodule

// File: rtl/rvm_mem_master.sv
// Core-side initiator for the stall/error SRAM bus: one request in flight,
// stall wait with optional timeout, aligned and extended read data return.
module rvm_mem_master
    import rvm_mem_master_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 255,
    parameter logic [31:0] RESET_ADDR  = RESET_ADDR_DEFAULT
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [31:0]             req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_err,
    rvm_mem_master_if.master        mem
);

    localparam int CNT_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_LIMIT - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              done, timeout, accept, bus_active;

    logic [31:0]       addr_p0;
    logic [31:0]       wdata_p0;
    mem_size_e         size_p0;
    logic              write_p0;
    logic              signed_p0;

    logic              misaligned;
    logic [3:0]        lane_ben;
    logic [31:0]       lane_wdata;
    logic [31:0]       rdata_ext;

    rvm_mem_master_align u_align (
        .size       (size_p0),
        .sign_ext   (signed_p0),
        .offset     (addr_p0[1:0]),
        .wdata      (wdata_p0),
        .rdata      (mem.mem_rdata),
        .misaligned (misaligned),
        .ben        (lane_ben),
        .wdata_lane (lane_wdata),
        .rdata_ext  (rdata_ext)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign accept    = req_valid & req_ready;

    // Misaligned requests still occupy the bus slot (with no enables) so the
    // response latency is the same as for a zero-stall aligned access.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        timeout = 1'b0;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_BUS;
            ST_BUS: begin
                if (misaligned || !mem.mem_stall) begin
                    done    = 1'b1;
                    state_d = ST_RESP;
                end else if (STALL_LIMIT != 0 && stall_cnt_q == STALL_MAX) begin
                    timeout = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and response registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            stall_cnt_q <= '0;
            rsp_rdata   <= 32'h0;
            rsp_err     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q != ST_BUS)
                stall_cnt_q <= '0;
            else if (mem.mem_stall)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (done) begin
                rsp_err   <= misaligned | mem.mem_error;
                rsp_rdata <= (misaligned | mem.mem_error | write_p0) ? 32'h0 : rdata_ext;
            end else if (timeout) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= 32'h0;
            end
        end
    end

    // Request capture; only meaningful while the FSM is past IDLE
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0   <= req_addr;
            wdata_p0  <= req_wdata;
            size_p0   <= mem_size_e'(req_size);
            write_p0  <= req_write;
            signed_p0 <= req_signed;
        end
    end

    // Bus outputs decode from registered state only, so they hold through
    // stalls and drop together with the asynchronous reset.
    assign bus_active    = (state_q == ST_BUS) && !misaligned;
    assign mem.mem_addr  = bus_active ? {addr_p0[31:2], 2'b00} : RESET_ADDR;
    assign mem.mem_ben   = bus_active ? lane_ben : 4'h0;
    assign mem.mem_wen   = bus_active & write_p0;
    assign mem.mem_wdata = bus_active ? lane_wdata : 32'h0;

endmodule
